// File: rtl/venus_pkg.sv
// Shared decode constants, field positions and width defaults.
// Small helpers classify opcodes for the decode stage.
package venus_pkg;

    localparam int DEF_ADDR      = 16;
    localparam int DEF_WORD      = 32;
    localparam int DEF_NREG_LOG2 = 5;

    localparam logic [5:0] OP_NOP         = 6'h00;
    localparam logic [5:0] OP_LOAD        = 6'h10;
    localparam logic [5:0] OP_STORE       = 6'h11;
    localparam logic [5:0] OP_BR_FIRST    = 6'h20;
    localparam logic [5:0] OP_BR_LAST     = 6'h23;
    localparam logic [5:0] OP_LOGIC_FIRST = 6'h0C;
    localparam logic [5:0] OP_LOGIC_LAST  = 6'h0E;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    function automatic logic rt_used(input logic [5:0] op);
        return (op == OP_NOP) || (op == OP_STORE);
    endfunction

    function automatic logic imm_zext(input logic [5:0] op);
        return (op >= OP_LOGIC_FIRST) && (op <= OP_LOGIC_LAST);
    endfunction

    function automatic logic is_br(input logic [5:0] op);
        return (op >= OP_BR_FIRST) && (op <= OP_BR_LAST);
    endfunction

endpackage

// File: rtl/idecode_if.sv
// Fetch/writeback inputs and decoded output bundle of the decode stage.
// slave: the decode stage; master: the surrounding pipeline.
interface idecode_if
    import venus_pkg::*;
#(
    parameter int ADDR      = DEF_ADDR,
    parameter int WORD      = DEF_WORD,
    parameter int NREG_LOG2 = DEF_NREG_LOG2
);
    logic [WORD-1:0]      inst_i;
    logic [ADDR-1:0]      pc_i;
    logic                 flush_i;
    logic                 stall_i;
    logic                 we_i;
    logic [NREG_LOG2-1:0] wa_i;
    logic [WORD-1:0]      wd_i;
    logic                 valid_o;
    logic [5:0]           opcode_o;
    logic [NREG_LOG2-1:0] rd_o;
    logic [WORD-1:0]      rs_val_o;
    logic [WORD-1:0]      rt_val_o;
    logic [WORD-1:0]      imm_o;
    logic                 is_load_o;
    logic                 is_store_o;
    logic                 is_branch_o;
    logic [ADDR-1:0]      branch_addr_o;
    logic                 stall_o;

    modport slave (
        input  inst_i, pc_i, flush_i, stall_i, we_i, wa_i, wd_i,
        output valid_o, opcode_o, rd_o, rs_val_o, rt_val_o, imm_o,
        output is_load_o, is_store_o, is_branch_o, branch_addr_o, stall_o
    );

    modport master (
        output inst_i, pc_i, flush_i, stall_i, we_i, wa_i, wd_i,
        input  valid_o, opcode_o, rd_o, rs_val_o, rt_val_o, imm_o,
        input  is_load_o, is_store_o, is_branch_o, branch_addr_o, stall_o
    );
endinterface

// File: rtl/idecode_regfile.sv
// 32-entry register file: two combinational reads, one sync write, r0 = 0.
// IDECODE_WB_BYPASS_EN makes same-cycle writes visible on the read ports.
module idecode_regfile
    import venus_pkg::*;
#(
    parameter int WORD      = DEF_WORD,
    parameter int NREG_LOG2 = DEF_NREG_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [NREG_LOG2-1:0] wa_i,
    input  logic [WORD-1:0]      wd_i,
    input  logic [NREG_LOG2-1:0] ra0_i,
    input  logic [NREG_LOG2-1:0] ra1_i,
    output logic [WORD-1:0]      rd0_o,
    output logic [WORD-1:0]      rd1_o
);
    localparam int NREG = 1 << NREG_LOG2;

    logic [WORD-1:0] mem_q [NREG];
    logic            wr_en;

    assign wr_en = we_i && (wa_i != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa_i] <= wd_i;
        end
    end

`ifdef IDECODE_WB_BYPASS_EN
    assign rd0_o = (ra0_i == '0) ? '0 :
                   (wr_en && ra0_i == wa_i) ? wd_i : mem_q[ra0_i];
    assign rd1_o = (ra1_i == '0) ? '0 :
                   (wr_en && ra1_i == wa_i) ? wd_i : mem_q[ra1_i];
`else
    assign rd0_o = (ra0_i == '0) ? '0 : mem_q[ra0_i];
    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
`endif
endmodule

// File: rtl/idecode.sv
// Decode stage: field split, operand read, immediate/branch target, hazards.
// Ports: clk, rst (async active-low), bus (idecode_if.slave).
// Optional macro IDECODE_WB_BYPASS_EN: writeback bypass instead of stall.
module idecode
    import venus_pkg::*;
#(
    parameter int ADDR      = DEF_ADDR,
    parameter int WORD      = DEF_WORD,
    parameter int NREG_LOG2 = DEF_NREG_LOG2
) (
    input  logic      clk,
    input  logic      rst,
    idecode_if.slave  bus
);
    typedef struct packed {
        logic                 valid;
        logic [5:0]           opcode;
        logic [NREG_LOG2-1:0] rd;
        logic [WORD-1:0]      rs_val;
        logic [WORD-1:0]      rt_val;
        logic [WORD-1:0]      imm;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
        logic [ADDR-1:0]      branch_addr;
    } id_ex_t;

    id_ex_t               out_q, out_d, dec;
    logic [5:0]           op;
    logic [NREG_LOG2-1:0] rd, rs, rt;
    logic [15:0]          imm16;
    logic [WORD-1:0]      rs_val, rt_val;
    logic                 rt_use, hz, wbh, bubble;

    assign op     = bus.inst_i[OP_HI:OP_LO];
    assign rd     = bus.inst_i[RD_HI:RD_LO];
    assign rs     = bus.inst_i[RS_HI:RS_LO];
    assign rt     = bus.inst_i[RT_HI:RT_LO];
    assign imm16  = bus.inst_i[IMM_HI:IMM_LO];
    assign rt_use = rt_used(op);

    idecode_regfile #(
        .WORD      (WORD),
        .NREG_LOG2 (NREG_LOG2)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we_i  (bus.we_i),
        .wa_i  (bus.wa_i),
        .wd_i  (bus.wd_i),
        .ra0_i (rs),
        .ra1_i (rt),
        .rd0_o (rs_val),
        .rd1_o (rt_val)
    );

    // Load in the output register feeding a source of the incoming word.
    assign hz = out_q.is_load && out_q.valid && (out_q.rd != '0) &&
                ((out_q.rd == rs) || (rt_use && out_q.rd == rt));

`ifdef IDECODE_WB_BYPASS_EN
    assign wbh = 1'b0;
`else
    // Without bypass the read would see the stale value: wait one edge.
    assign wbh = bus.we_i && (bus.wa_i != '0) &&
                 ((bus.wa_i == rs) || (rt_use && bus.wa_i == rt));
`endif

    assign bubble      = hz || wbh;
    assign bus.stall_o = !bus.flush_i && (bus.stall_i || bubble);

    always_comb begin
        dec             = '0;
        dec.valid       = 1'b1;
        dec.opcode      = op;
        dec.rd          = rd;
        dec.rs_val      = rs_val;
        dec.rt_val      = rt_val;
        dec.imm         = imm_zext(op) ? {{(WORD-16){1'b0}}, imm16}
                                       : {{(WORD-16){imm16[15]}}, imm16};
        dec.is_load     = (op == OP_LOAD);
        dec.is_store    = (op == OP_STORE);
        dec.is_branch   = is_br(op);
        dec.branch_addr = bus.pc_i + ADDR'(1) + ADDR'(imm16);
    end

    always_comb begin
        out_d = out_q;
        if (bus.flush_i) begin
            out_d = '0;
        end else if (bus.stall_i) begin
            out_d = out_q;
        end else if (bubble) begin
            out_d = '0;
        end else begin
            out_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.valid_o       = out_q.valid;
    assign bus.opcode_o      = out_q.opcode;
    assign bus.rd_o          = out_q.rd;
    assign bus.rs_val_o      = out_q.rs_val;
    assign bus.rt_val_o      = out_q.rt_val;
    assign bus.imm_o         = out_q.imm;
    assign bus.is_load_o     = out_q.is_load;
    assign bus.is_store_o    = out_q.is_store;
    assign bus.is_branch_o   = out_q.is_branch;
    assign bus.branch_addr_o = out_q.branch_addr;
endmodule

// File: tb/tb_idecode.sv
// Scoreboard bench for idecode: driver queues hand-computed bundles,
// a monitor pops and compares one after every clock edge.
module tb_idecode;
    import venus_pkg::*;

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
        logic        ld;
        logic        st;
        logic        br;
        logic [15:0] ba;
    } exp_t;

    localparam logic [31:0] R1 = 32'h11111111;
    localparam logic [31:0] R2 = 32'h22222222;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam exp_t        BUB = '0;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    idecode_if bus ();

    idecode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(
        input logic v, input logic [5:0] op, input logic [4:0] rd,
        input logic [31:0] rsv, input logic [31:0] rtv,
        input logic [31:0] imm, input logic ld, input logic st,
        input logic br, input logic [15:0] ba);
        exp_t e;
        e.v = v; e.op = op; e.rd = rd; e.rsv = rsv; e.rtv = rtv;
        e.imm = imm; e.ld = ld; e.st = st; e.br = br; e.ba = ba;
        return e;
    endfunction

    function automatic exp_t act();
        return mk(bus.valid_o, bus.opcode_o, bus.rd_o, bus.rs_val_o,
                  bus.rt_val_o, bus.imm_o, bus.is_load_o,
                  bus.is_store_o, bus.is_branch_o, bus.branch_addr_o);
    endfunction

    task automatic chk_stall(input string nm, input logic xs);
        checks++;
        if (bus.stall_o !== xs) begin
            errors++;
            $display("FAIL %s stall_o: got %b want %b", nm, bus.stall_o, xs);
        end
    endtask

    task automatic cyc(
        input string nm, input logic [31:0] inst, input logic [15:0] pc,
        input logic fl, input logic st, input logic we,
        input logic [4:0] wa, input logic [31:0] wd,
        input logic xs, input exp_t e);
        @(negedge clk);
        rst         = 1'b1;
        bus.inst_i  = inst;
        bus.pc_i    = pc;
        bus.flush_i = fl;
        bus.stall_i = st;
        bus.we_i    = we;
        bus.wa_i    = wa;
        bus.wd_i    = wd;
        q.push_back(e);
        #1;
        chk_stall(nm, xs);
    endtask

    task automatic rcyc(input logic [31:0] inst, input logic [15:0] pc);
        @(negedge clk);
        rst         = 1'b0;
        bus.inst_i  = inst;
        bus.pc_i    = pc;
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.we_i    = 1'b0;
        q.push_back(BUB);
        #1;
        chk_stall("reset", 1'b0);
        checks++;
        if (act() !== BUB) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", act(), BUB);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = act();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL bundle: got v=%b op=%h rd=%0d rs=%h rt=%h imm=%h ld=%b st=%b br=%b ba=%h want v=%b op=%h rd=%0d rs=%h rt=%h imm=%h ld=%b st=%b br=%b ba=%h",
                             a.v, a.op, a.rd, a.rsv, a.rtv, a.imm, a.ld, a.st, a.br, a.ba,
                             e.v, e.op, e.rd, e.rsv, e.rtv, e.imm, e.ld, e.st, e.br, e.ba);
                end
            end
        end
    end

    initial begin : driver
        rst         = 1'b0;
        bus.inst_i  = '0;
        bus.pc_i    = '0;
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.we_i    = 1'b0;
        bus.wa_i    = '0;
        bus.wd_i    = '0;
        rcyc(32'h0, 16'h0);
        rcyc(32'h0, 16'h0);

        cyc("nop_wr_r1", 32'h0, 16'h0000, 0, 0, 1, 5'd1, R1, 0,
            mk(1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0001));
        cyc("nop_wr_r2", 32'h0, 16'h0001, 0, 0, 1, 5'd2, R2, 0,
            mk(1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0002));
        cyc("wr_r0", 32'h00800000, 16'h0002, 0, 0, 1, 5'd0, 32'h1234, 0,
            mk(1, 6'h00, 4, 0, 0, 0, 0, 0, 0, 16'h0003));
        cyc("rd_r0", 32'h00800000, 16'h0003, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h00, 4, 0, 0, 0, 0, 0, 0, 16'h0004));
        cyc("store", 32'h44011000, 16'h0004, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h11, 0, R1, R2, 32'h1000, 0, 1, 0, 16'h1005));
        cyc("load_r3", 32'h40610000, 16'h0005, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h10, 3, R1, 0, 0, 1, 0, 0, 16'h0006));
        cyc("luse_rs", 32'h00A30000, 16'h0006, 0, 0, 0, 5'd0, 0, 1, BUB);
        cyc("luse_go", 32'h00A30000, 16'h0006, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h00, 5, 0, 0, 0, 0, 0, 0, 16'h0007));
        cyc("load_r2", 32'h40400000, 16'h0008, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h10, 2, 0, 0, 0, 1, 0, 0, 16'h0009));
        cyc("flush_all", 32'h00020000, 16'h0009, 1, 1, 0, 5'd0, 0, 0, BUB);
        cyc("after_fl", 32'h00020000, 16'h0009, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h00, 0, R2, 0, 0, 0, 0, 0, 16'h000A));
        cyc("hold", 32'h00010000, 16'h0020, 0, 1, 0, 5'd0, 0, 1,
            mk(1, 6'h00, 0, R2, 0, 0, 0, 0, 0, 16'h000A));
        cyc("br_wrap", 32'h80000000, 16'hFFFF, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h20, 0, 0, 0, 0, 0, 0, 1, 16'h0000));
        cyc("br_neg", 32'h8000FFFE, 16'h0010, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h20, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 1, 16'h000F));
        cyc("zext", 32'h30008001, 16'h0030, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h0C, 0, 0, 0, 32'h00008001, 0, 0, 0, 16'h8032));
`ifdef IDECODE_WB_BYPASS_EN
        cyc("wb_same", 32'h00050000, 16'h0040, 0, 0, 1, 5'd5, DB, 0,
            mk(1, 6'h00, 0, DB, 0, 0, 0, 0, 0, 16'h0041));
`else
        cyc("wb_same", 32'h00050000, 16'h0040, 0, 0, 1, 5'd5, DB, 1, BUB);
`endif
        cyc("wb_next", 32'h00050000, 16'h0040, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h00, 0, DB, 0, 0, 0, 0, 0, 16'h0041));
        rcyc(32'h00010000, 16'h0050);
        rcyc(32'h00010000, 16'h0050);
        cyc("post_rst", 32'h00010000, 16'h0050, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0051));
        cyc("load_r1", 32'h40200000, 16'h0060, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h10, 1, 0, 0, 0, 1, 0, 0, 16'h0061));
        cyc("luse_rt", 32'h44000800, 16'h0061, 0, 0, 0, 5'd0, 0, 1, BUB);
        cyc("rt_go", 32'h44000800, 16'h0061, 0, 0, 0, 5'd0, 0, 0,
            mk(1, 6'h11, 0, 0, 0, 32'h00000800, 0, 1, 0, 16'h0862));

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/idecode.md
Name: idecode

Overview:
Instruction-decode stage, directly downstream of the fetch stage. Latches the fetched word and its PC, and splits fields. Reads two operands from an internal 32x32 register file (write port driven by writeback) and builds the immediate and branch target. Detects load-use hazards, back-pressures fetch via stall_o, and inserts bubbles. Honours flush from execute.

Parameters:
ADDR, 16, instruction address width
WORD, 32, instruction/data word width
NREG_LOG2, 5, register index width (32 registers, r0 hard-wired zero)

Ports:
clk  in  1  clock
rst  in  1  reset (see Behaviour)
inst_i  in  WORD  instruction word from fetch
pc_i  in  ADDR  PC accompanying inst_i
flush_i  in  1  execute-stage branch taken: squash this stage
stall_i  in  1  downstream hold
we_i  in  1  writeback register write enable
wa_i  in  NREG_LOG2  writeback register index
wd_i  in  WORD  writeback data
valid_o  out  1  output bundle holds a real instruction
opcode_o  out  6  inst[31:26]
rd_o  out  NREG_LOG2  inst[25:21]
rs_val_o, rt_val_o  out  WORD  operand values for inst[20:16], inst[15:11]
imm_o  out  WORD  extended immediate
is_load_o, is_store_o, is_branch_o  out  1  class flags
branch_addr_o  out  ADDR  pc_i+1+imm[15:0], mod 2^ADDR
stall_o  out  1  to fetch stall_i, combinational

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- On reset, every registered output is 0, which makes the output bundle a bubble. All register-file entries reset to 0.
- Decode rules:
  - opcode 0x10 = load; 0x11 = store; 0x20-0x23 = branch.
  - rt is a used source only when the opcode is 0x00 or 0x11.
  - Immediate is zero-extended for opcodes 0x0C-0x0E and sign-extended otherwise.
- Latency: decode is 1 cycle. Register-file read is combinational, and the result is captured in the output register at the clock edge.
- Hazard detection (hz): asserted when is_load_o && valid_o && rd_o!=0 && (rd_o==rs || (rt used && rd_o==rt)).
- Per-edge priority:
  1. flush_i=1: load bubble (valid_o=0, flags 0). stall_o is forced 0 this cycle.
  2. stall_i=1: hold all outputs. stall_o=1.
  3. hz=1: load bubble. stall_o=1, so fetch re-presents the same inst_i/pc_i.
  4. Otherwise: capture the decoded inst_i with valid_o=1.
- inst_i==0 decodes as a NOP with valid_o=1. It never triggers hz.
- Register file: write on the edge when we_i && wa_i!=0. Writes to r0 are ignored, and reads of r0 return 0.
- Register-file writes occur even during stall or flush.
- Reset mid-operation clears any pending bubble/hold state immediately. The first post-reset edge decodes normally.
- branch_addr_o wraps: 0xFFFF+1+0 = 0x0000.

Optional Feature:
IDECODE_WB_BYPASS_EN.
- Defined: write-through. If we_i && wa_i!=0 && wa_i equals a read index in the same cycle, the read returns wd_i.
- Undefined: the read returns the old value. stall_o (and a bubble) is additionally asserted when we_i && wa_i!=0 && wa_i matches a used source. The write then lands, and the next cycle reads the new value.

Decomposition:
- Shared package venus_pkg holds:
  - opcode constants: OP_NOP=0x00, OP_LOAD=0x10, OP_STORE=0x11, OP_BR_FIRST=0x20, OP_BR_LAST=0x23, OP_LOGIC_FIRST=0x0C, OP_LOGIC_LAST=0x0E
  - field bit positions
  - ADDR/WORD defaults
- One sub-module, regfile: 2 combinational read ports, 1 synchronous write port, and the r0 rule.
- The bypass mux lives in regfile, under the macro.

Test Plan:
- Reset mid-stream (rst low 2 cycles) -> all outputs 0, valid_o=0, stall_o=0; the next edge decodes inst_i normally.
- Load r3 (0x40600000+...), followed by an instruction with rs=3 -> stall_o=1 for 1 cycle and one bubble; pc_i is held, then the dependent instruction decodes with valid_o=1.
- Same-cycle we_i=1, wa_i=5, wd_i=0xDEADBEEF, with inst rs=5:
  - macro on -> rs_val_o=0xDEADBEEF, no stall.
  - macro off -> one stall, then 0xDEADBEEF.
- flush_i=1 together with a hazard and stall_i=1 -> bubble loaded, stall_o=0.
- Branch opcode 0x20, pc_i=0xFFFF, imm=0x0000 -> branch_addr_o=0x0000, is_branch_o=1.
- Branch opcode 0x20, pc_i=0x0010, imm=0xFFFE -> branch_addr_o=0x000F, imm_o=0xFFFFFFFE.
- Opcode 0x0C, imm 0x8001 -> imm_o=0x00008001.
- Write to r0 with wd_i=0x1234 -> reads of r0 return 0.
